// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles every non-clock signal of the data RAM arbiter: the pipeline
//   memory-stage port, the external agent (loader / debug DMA) port and the
//   dual-port RAM pins.
//   slave  : arbiter view (pipeline/external requests in, RAM pins out)
//   master : environment view (pipeline, external agent and RAM model)
interface data_mem_arbiter_if;
    // pipeline memory stage
    logic        p_req;
    logic [1:0]  p_we;
    logic [31:0] p_waddr;
    logic [63:0] p_wdata;
    logic [31:0] p_raddr;
    logic        p_stall;
    logic [63:0] p_rdata;
    // external agent
    logic        x_valid;
    logic        x_ready;
    logic [1:0]  x_we;
    logic [31:0] x_addr;
    logic [63:0] x_wdata;
    logic        x_rvalid;
    logic [63:0] x_rdata;
    // RAM, port A write / port B read
    logic [7:0]  ram_wea;
    logic [31:0] ram_addra;
    logic [63:0] ram_dina;
    logic [31:0] ram_addrb;
    logic [63:0] ram_doutb;

    modport slave (
        input  p_req, p_we, p_waddr, p_wdata, p_raddr,
        output p_stall, p_rdata,
        input  x_valid, x_we, x_addr, x_wdata,
        output x_ready, x_rvalid, x_rdata,
        output ram_wea, ram_addra, ram_dina, ram_addrb,
        input  ram_doutb
    );

    modport master (
        output p_req, p_we, p_waddr, p_wdata, p_raddr,
        input  p_stall, p_rdata,
        output x_valid, x_we, x_addr, x_wdata,
        input  x_ready, x_rvalid, x_rdata,
        input  ram_wea, ram_addra, ram_dina, ram_addrb,
        output ram_doutb
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the 64-bit dual-port data RAM between the pipeline memory stage
//   (priority) and an external agent. An external request waiting behind the
//   pipeline for MAX_WAIT cycles steals the next cycle, stalling the pipeline.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : data_mem_arbiter_if.slave (pipeline, external and RAM signals)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   NORMAL | pipeline owns the RAM when p_req=1, otherwise external agent
//   STEAL  | external agent owns the RAM for one cycle, pipeline stalled
module data_mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);

    typedef enum logic {NORMAL = 1'b0, STEAL = 1'b1} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       rd_pend_q, rd_pend_d;

    logic       p_grant;
    logic       x_accept;

    // Grant is decided purely from the current state and request lines.
    assign p_grant  = (state_q == NORMAL) && bus.p_req;
    assign x_accept = !p_grant && bus.x_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NORMAL;
            wcnt_q    <= 8'd0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d   = NORMAL;
        wcnt_d    = wcnt_q;
        rd_pend_d = x_accept && (bus.x_we == 2'b00);

        if (x_accept)
            wcnt_d = 8'd0;
        else if (bus.x_valid && (wcnt_q != 8'hFF))
            wcnt_d = wcnt_q + 8'd1;

        // STEAL always falls back to NORMAL, so it never lasts two cycles.
        if ((state_q == NORMAL) && bus.x_valid && bus.p_req && (wcnt_q == WAIT_LAST))
            state_d = STEAL;
    end

    always_comb begin
        bus.p_stall   = (state_q == STEAL);
        bus.x_ready   = x_accept;
        bus.x_rvalid  = rd_pend_q;
        bus.x_rdata   = bus.ram_doutb;
        bus.p_rdata   = bus.ram_doutb;

        bus.ram_wea   = 8'h00;
        bus.ram_addra = bus.p_waddr;
        bus.ram_dina  = bus.p_wdata;
        bus.ram_addrb = bus.p_raddr;

        if (p_grant) begin
            bus.ram_wea = {{4{bus.p_we[1]}}, {4{bus.p_we[0]}}};
        end else if (x_accept) begin
            bus.ram_addra = bus.x_addr;
            bus.ram_addrb = bus.x_addr;
            bus.ram_dina  = bus.x_wdata;
            bus.ram_wea   = {{4{bus.x_we[1]}}, {4{bus.x_we[0]}}};
        end
        // STEAL with x_valid low leaves wea at zero: an idle stalled cycle.
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(int i);
        return {16'hC0DE, 16'(i), 16'h5A5A, 16'(i)};
    endfunction

    // RAM model: 128 x 64-bit words, byte write enables, registered read.
    logic [63:0] mem [0:127];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= pat(i);
            bus.ram_doutb <= 64'd0;
        end else begin
            for (int b = 0; b < 8; b++)
                if (bus.ram_wea[b])
                    mem[bus.ram_addra[9:3]][8*b +: 8] <= bus.ram_dina[8*b +: 8];
            bus.ram_doutb <= mem[bus.ram_addrb[9:3]];
        end
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.p_req = 0; bus.p_we = 0; bus.p_waddr = 0; bus.p_wdata = 0; bus.p_raddr = 0;
        bus.x_valid = 0; bus.x_we = 0; bus.x_addr = 0; bus.x_wdata = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.p_stall, 0);
        chk("rst_rvalid", bus.x_rvalid, 0);
        chk("rst_ready", bus.x_ready, 0);
        chk("rst_wea", bus.ram_wea, 0);
        rst = 1'b0;
        tick();

        // back-to-back external reads 0x0..0x18
        for (int i = 0; i < 4; i++) begin
            bus.x_valid = 1; bus.x_we = 2'b00; bus.x_addr = 32'(i * 8);
            #1;
            chk("b2b_ready", bus.x_ready, 1);
            chk("b2b_addrb", bus.ram_addrb, 64'(i * 8));
            if (i > 0) begin
                chk("b2b_rvalid", bus.x_rvalid, 1);
                chk("b2b_rdata", bus.x_rdata, pat(i - 1));
            end
            tick();
        end
        bus.x_valid = 0;
        #1;
        chk("b2b_rvalid_last", bus.x_rvalid, 1);
        chk("b2b_rdata_last", bus.x_rdata, pat(3));
        tick();
        chk("b2b_rvalid_off", bus.x_rvalid, 0);

        // pipeline write then read of 0x10
        bus.p_req = 1; bus.p_we = 2'b11; bus.p_waddr = 32'h10;
        bus.p_wdata = 64'hAAAA_BBBB_1111_2222; bus.p_raddr = 32'h0;
        #1;
        chk("p_wea", bus.ram_wea, 8'hFF);
        chk("p_addra", bus.ram_addra, 32'h10);
        chk("p_stall_w", bus.p_stall, 0);
        tick();
        bus.p_we = 2'b00; bus.p_raddr = 32'h10;
        #1;
        chk("p_wea_rd", bus.ram_wea, 0);
        chk("p_stall_r", bus.p_stall, 0);
        tick();
        bus.p_req = 0;
        #1;
        chk("p_rdata", bus.p_rdata, 64'hAAAA_BBBB_1111_2222);
        chk("p_stall_after", bus.p_stall, 0);

        // external lower-lane write then read of 0x20
        bus.x_valid = 1; bus.x_we = 2'b01; bus.x_addr = 32'h20;
        bus.x_wdata = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("x_ready_w", bus.x_ready, 1);
        chk("x_wea", bus.ram_wea, 8'h0F);
        chk("x_addra", bus.ram_addra, 32'h20);
        tick();
        bus.x_we = 2'b00;
        #1;
        chk("x_ready_r", bus.x_ready, 1);
        chk("x_rvalid_after_w", bus.x_rvalid, 0);
        tick();
        bus.x_valid = 0;
        #1;
        chk("x_rvalid", bus.x_rvalid, 1);
        chk("x_rdata_lo", bus.x_rdata[31:0], 32'hDEADBEEF);
        chk("x_rdata", bus.x_rdata, {16'hC0DE, 16'h0004, 32'hDEADBEEF});
        tick();

        // starvation, MAX_WAIT=4: steal on cycle 4
        bus.p_req = 1; bus.p_we = 2'b00; bus.p_waddr = 32'h0;
        bus.x_valid = 1; bus.x_we = 2'b01; bus.x_addr = 32'h30; bus.x_wdata = 64'h1234;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("starve_ready_c%0d", c), bus.x_ready, (c == 4));
            chk($sformatf("starve_stall_c%0d", c), bus.p_stall, (c == 4));
            chk($sformatf("starve_wea_c%0d", c), bus.ram_wea, (c == 4) ? 8'h0F : 8'h00);
            if (c == 3) chk("starve_wcnt3", dut.wcnt_q, 3);
            if (c == 4) chk("starve_addra", bus.ram_addra, 32'h30);
            if (c == 5) chk("starve_wcnt5", dut.wcnt_q, 0);
            tick();
        end
        // flush: pipeline idle lets the waiting write through, clearing wcnt
        bus.p_req = 0;
        tick();

        // release before steal: p_req drops at cycle 2
        for (int c = 0; c < 4; c++) begin
            bus.p_req = (c < 2); bus.x_valid = (c < 3);
            #1;
            chk($sformatf("rel_ready_c%0d", c), bus.x_ready, (c == 2));
            chk($sformatf("rel_stall_c%0d", c), bus.p_stall, 0);
            if (c == 1) chk("rel_wcnt1", dut.wcnt_q, 1);
            if (c == 3) chk("rel_wcnt3", dut.wcnt_q, 0);
            tick();
        end

        // x_valid dropped during STEAL: idle stalled cycle
        bus.p_req = 1; bus.x_we = 2'b00; bus.x_addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            bus.x_valid = (c < 4);
            #1;
            if (c == 4) begin
                chk("viol_stall", bus.p_stall, 1);
                chk("viol_ready", bus.x_ready, 0);
                chk("viol_wea", bus.ram_wea, 0);
            end
            if (c == 5) begin
                chk("viol_rvalid", bus.x_rvalid, 0);
                chk("viol_stall_off", bus.p_stall, 0);
            end
            tick();
        end

        // reset in the same cycle as an accepted external read
        bus.p_req = 0; bus.x_valid = 1; bus.x_we = 2'b00; bus.x_addr = 32'h8;
        #1;
        chk("rmr_ready", bus.x_ready, 1);
        #2;
        rst = 1'b1; bus.x_valid = 0;
        #1;
        chk("rmr_ready_rst", bus.x_ready, 0);
        chk("rmr_rvalid_rst", bus.x_rvalid, 0);
        tick();
        chk("rmr_rvalid", bus.x_rvalid, 0);
        chk("rmr_stall", bus.p_stall, 0);
        chk("rmr_wea", bus.ram_wea, 0);
        chk("rmr_wcnt", dut.wcnt_q, 0);
        rst = 1'b0;
        tick();
        chk("rmr_rvalid_post", bus.x_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single dual-port data RAM (64-bit, two 32-bit lanes, port A write / port B read, 1-cycle registered read) between the pipeline memory stage and an external agent (loader / debug DMA). The pipeline has priority; an anti-starvation counter lets a waiting external request steal one cycle. It does so by raising a one-cycle stall to the pipeline. The block sits between the memory stage and the RAM instance and owns all RAM port signals.

## Interface
- MAX_WAIT, 15: cycles an external request may wait behind the pipeline before a steal; legal range 1..255.
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- p_req  in  1  pipeline memory stage issues a bundle this cycle
- p_we  in  2  pipeline lane write enables: [1] upper lane, [0] lower lane
- p_waddr  in  32  pipeline write address
- p_wdata  in  64  pipeline write data, {upper, lower}
- p_raddr  in  32  pipeline read address
- p_stall  out  1  interlock to pipeline; the bundle presented this cycle is not performed and must be re-presented
- p_rdata  out  64  RAM port-B data; valid the cycle after a granted pipeline read
- x_valid  in  1  external request valid; held with payload until accepted
- x_ready  out  1  external request accepted this cycle
- x_we  in  2  external lane write enables; 2'b00 means read
- x_addr  in  32  external address, used for both read and write
- x_wdata  in  64  external write data
- x_rvalid  out  1  external read data valid
- x_rdata  out  64  external read data
- ram_wea  out  8  RAM port-A byte enables
- ram_addra  out  32  RAM port-A address
- ram_dina  out  64  RAM port-A data
- ram_addrb  out  32  RAM port-B address
- ram_doutb  in  64  RAM port-B data, 1-cycle latency

## Operation
- Registered state: FSM {NORMAL, STEAL}, wait counter wcnt (8 bits, saturating), rd_pend (external read issued last cycle).
- Grant is combinational from the current state:
  - NORMAL, p_req=1: pipeline granted; x_ready=0.
  - NORMAL, p_req=0: external granted; x_ready=x_valid.
  - STEAL: external granted unconditionally; x_ready=x_valid; p_stall=1.
- p_stall=1 only in STEAL. The FSM is never in STEAL for two consecutive cycles.
- Pipeline granted:
  - ram_addra=p_waddr, ram_dina=p_wdata, ram_addrb=p_raddr.
  - ram_wea={{4{p_we[1]}},{4{p_we[0]}}}.
- External granted with x_valid:
  - ram_addra=ram_addrb=x_addr, ram_dina=x_wdata.
  - ram_wea built from x_we the same way.
- When nobody issues a write, ram_wea=0. Addresses default to the pipeline inputs.
- wcnt:
  - Cleared on x_ready.
  - Incremented when x_valid=1 and x_ready=0.
  - Holds otherwise (no valid request).
- NORMAL to STEAL when x_valid & p_req & (wcnt == MAX_WAIT-1) in the same cycle. STEAL always returns to NORMAL.
- If x_valid drops in STEAL (protocol violation), the cycle is idle: wea=0, no rvalid, stall still asserted.
- rd_pend is set when an external read (x_we=00) is accepted. Next cycle: x_rvalid=1 and x_rdata=ram_doutb.
- p_rdata=ram_doutb always (passthrough). It is meaningful only the cycle after a pipeline grant.

## Timing
- Reset values: FSM=NORMAL, wcnt=0, rd_pend=0, so x_rvalid=0 and p_stall=0. Combinational outputs follow from that state.
- Read latency is exactly 1 cycle for both requesters. Writes take effect at the grant edge.
- Worst-case external wait is MAX_WAIT cycles. The steal occurs on cycle MAX_WAIT+1 of waiting.
- Back-to-back external accepts are allowed every cycle while p_req=0. rd_pend is then refreshed each cycle.
- Reset asserted mid-operation: the pending external read is dropped (no x_rvalid), and a steal in progress is cancelled.
- Simultaneous p_req and x_valid with wcnt < MAX_WAIT-1: pipeline wins and wcnt increments.

## Test plan
- Pipeline only:
  - Stimulus: p_req=1, p_we=2'b11, p_waddr=0x10, p_wdata=0xAAAA_BBBB_1111_2222; next cycle p_raddr=0x10.
  - Required: ram_wea=0xFF on the write; the cycle after the read, p_rdata=0xAAAA_BBBB_1111_2222; p_stall=0 throughout.
- External only:
  - Stimulus: p_req=0, x_we=2'b01, x_addr=0x20, x_wdata=0x0000_0000_DEAD_BEEF; then a read of 0x20.
  - Required: ram_wea=0x0F on the write; x_ready=1 both cycles; x_rvalid=1 one cycle after the read with x_rdata[31:0]=0xDEADBEEF.
- Starvation, MAX_WAIT=4:
  - Stimulus: p_req held 1, x_valid held 1 from cycle 0.
  - Required: x_ready=0 for cycles 0-3; cycle 4 STEAL with p_stall=1 and x_ready=1; cycle 5 p_stall=0 and wcnt=0.
- Release before steal:
  - Stimulus: p_req drops at cycle 2 while x_valid=1.
  - Required: x_ready=1 at cycle 2; wcnt cleared; no p_stall.
- Reset mid-read:
  - Stimulus: external read accepted, then rst asserted in the same cycle before the next edge.
  - Required: x_rvalid stays 0; all outputs at reset values.
- Back-to-back external reads:
  - Stimulus: four external reads at consecutive cycles to 0x0, 0x8, 0x10, 0x18 with p_req=0.
  - Required: x_rvalid high for four consecutive cycles, each with data from the matching address.
